// File: rtl/lsu_if.sv
// Core-side request bus and memory-side port of the load/store unit,
// bundled so the LSU and its environment connect through one handle.
// slave  : the LSU's view (takes core requests, drives the memory).
// master : the environment's view (core plus data memory).
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req_i;
  logic              core_we_i;
  logic [2:0]        core_size_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [DATA_W-1:0] core_wd_i;
  logic [DATA_W-1:0] core_rd_o;
  logic              core_stall_o;
  logic              core_err_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wd_o;
  logic [DATA_W-1:0] mem_rd_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i,
    output core_rd_o, core_stall_o, core_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wd_o
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i,
    input  core_rd_o, core_stall_o, core_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: turns RISC-V byte/half/word loads and stores into accesses
// on a word-only, single-cycle-latency memory. Sub-word stores are done by
// read-modify-write because the memory has no byte enables.
module lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic   clk_i,
  input logic   rst_i,
  lsu_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_READ  = 2'd2,
    RMW_WRITE = 2'd3
  } state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [2:0]        size_r;
  logic [15:0]       wd_r;      // only the low half is ever merged into memory
  logic [DATA_W-1:0] merge_r;

  logic              err_s;
  logic              accept_s;
  logic [DATA_W-1:0] core_rd_s;
  logic              core_stall_s;
  logic              core_err_s;
  logic              mem_req_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wd_s;

  // Misaligned halves/words, reserved sizes and unsigned store sizes are illegal.
  function automatic logic access_err(input logic we, input logic [2:0] size,
                                      input logic [1:0] lo);
    logic e;
    e = 1'b0;
    case (size)
      SZ_B:    e = 1'b0;
      SZ_H:    e = lo[0];
      SZ_W:    e = (lo != 2'b00);
      SZ_BU:   e = we;
      SZ_HU:   e = we | lo[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Pick the addressed lane(s) out of the memory word and extend to 32 bits.
  function automatic logic [DATA_W-1:0] load_extract(input logic [2:0] size,
                                                     input logic [1:0] lo,
                                                     input logic [DATA_W-1:0] word);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    r = {{(DATA_W-8){b[7]}}, b};
      SZ_H:    r = {{(DATA_W-16){h[15]}}, h};
      SZ_W:    r = word;
      SZ_BU:   r = {{(DATA_W-8){1'b0}}, b};
      SZ_HU:   r = {{(DATA_W-16){1'b0}}, h};
      default: r = {DATA_W{1'b0}};
    endcase
    return r;
  endfunction

  // Replace the target byte or half of the old word with the store data.
  function automatic logic [DATA_W-1:0] store_merge(input logic half,
                                                    input logic [1:0] lo,
                                                    input logic [DATA_W-1:0] word,
                                                    input logic [15:0] wd);
    logic [DATA_W-1:0] r;
    r = word;
    if (half) begin
      r[{lo[1], 4'b0000} +: 16] = wd;
    end else begin
      r[{lo, 3'b000} +: 8] = wd[7:0];
    end
    return r;
  endfunction

  assign err_s = access_err(bus.core_we_i, bus.core_size_i, bus.core_addr_i[1:0]);

  // Next-state and output decode; reset forces every output low so no write
  // can leave the unit while reset is being sampled.
  always_comb begin
    state_s      = state_r;
    accept_s     = 1'b0;
    core_rd_s    = {DATA_W{1'b0}};
    core_stall_s = 1'b0;
    core_err_s   = 1'b0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = {ADDR_W{1'b0}};
    mem_wd_s     = {DATA_W{1'b0}};
    if (rst_i) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.core_req_i) begin
            if (err_s) begin
              core_err_s = 1'b1;
            end else begin
              accept_s   = 1'b1;
              mem_req_s  = 1'b1;
              mem_addr_s = {bus.core_addr_i[ADDR_W-1:2], 2'b00};
              if (bus.core_we_i) begin
                if (bus.core_size_i == SZ_W) begin
                  mem_we_s = 1'b1;
                  mem_wd_s = bus.core_wd_i;
                end else begin
                  core_stall_s = 1'b1;
                  state_s      = RMW_READ;
                end
              end else begin
                core_stall_s = 1'b1;
                state_s      = LOAD_WAIT;
              end
            end
          end else begin
            state_s = IDLE;
          end
        end
        LOAD_WAIT: begin
          mem_addr_s = {addr_r[ADDR_W-1:2], 2'b00};
          core_rd_s  = load_extract(size_r, addr_r[1:0], bus.mem_rd_i);
          state_s    = IDLE;
        end
        RMW_READ: begin
          mem_addr_s   = {addr_r[ADDR_W-1:2], 2'b00};
          core_stall_s = 1'b1;
          state_s      = RMW_WRITE;
        end
        RMW_WRITE: begin
          mem_addr_s = {addr_r[ADDR_W-1:2], 2'b00};
          mem_req_s  = 1'b1;
          mem_we_s   = 1'b1;
          mem_wd_s   = merge_r;
          state_s    = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, captured operation and read-modify-write merge word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      size_r  <= 3'b000;
      wd_r    <= 16'h0000;
      merge_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        addr_r <= bus.core_addr_i;
        size_r <= bus.core_size_i;
        wd_r   <= bus.core_wd_i[15:0];
      end else begin
        addr_r <= addr_r;
        size_r <= size_r;
        wd_r   <= wd_r;
      end
      if (state_r == RMW_READ) begin
        merge_r <= store_merge(size_r[0], addr_r[1:0], bus.mem_rd_i, wd_r);
      end else begin
        merge_r <= merge_r;
      end
    end
  end

  assign bus.core_rd_o    = core_rd_s;
  assign bus.core_stall_o = core_stall_s;
  assign bus.core_err_o   = core_err_s;
  assign bus.mem_req_o    = mem_req_s;
  assign bus.mem_we_o     = mem_we_s;
  assign bus.mem_addr_o   = mem_addr_s;
  assign bus.mem_wd_o     = mem_wd_s;

endmodule
